// File: rtl/surf_scaler_bank.sv
// 32-channel trigger-rate scaler bank: counts trigger and reference-pulse edges over a
// fixed gate period, snapshots them into a holding bank and serves it to the HK readout.
module surf_scaler_bank #(
  parameter int PERIOD_CLKS = 33000000,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      trig_i,
  input  logic [31:0]      mask_i,
  input  logic             refpulse_i,
  input  logic [4:0]       scal_addr_i,
  input  logic             scal_rd_i,
  output logic [CNT_W-1:0] scal_dat_o,
  output logic [CNT_W-1:0] refpulse_cnt_o,
  output logic             scal_new_o,
  output logic             latch_o
);

  localparam int TMR_W = $clog2(PERIOD_CLKS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, READING} state_t;

  state_t           state_reg;
  logic             pending_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [31:0]      trig_q_reg;
  logic             ref_q_reg;
  logic [CNT_W-1:0] cnt_reg     [32];
  logic [CNT_W-1:0] cnt_next    [32];
  logic [CNT_W-1:0] holding_reg [32];
  logic [CNT_W-1:0] ref_cnt_reg;
  logic [CNT_W-1:0] ref_cnt_next;
  logic [CNT_W-1:0] ref_latch_reg;
  logic             scal_new_reg;

  logic [31:0] trig_en;
  logic        ref_en;
  logic        expire;
  logic        rd_first;
  logic        rd_last;
  logic        force_snap;
  logic        snap;

  // On a snapshot cycle the counter restarts at this cycle's enable so no edge is lost.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur,
                                                input logic inc, input logic restart);
    if (restart) return {{(CNT_W-1){1'b0}}, inc};
    if (inc && cur != CNT_MAX) return cur + 1'b1;
    return cur;
  endfunction

  assign trig_en    = trig_i & ~trig_q_reg & ~mask_i;
  assign ref_en     = refpulse_i & ~ref_q_reg;
  assign expire     = (timer_reg == TMR_LAST);
  assign rd_first   = scal_rd_i && (scal_addr_i == 5'd0);
  assign rd_last    = scal_rd_i && (scal_addr_i == 5'd31);
  // A second expire while already deferred forces the snapshot, capping deferral at one period.
  assign force_snap = (state_reg == READING) && pending_reg && expire;
  assign snap       = ((state_reg == IDLE) && (expire || pending_reg)) || force_snap;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_chan
      assign cnt_next[gi] = cnt_step(cnt_reg[gi], trig_en[gi], snap);
    end
  endgenerate

  assign ref_cnt_next = cnt_step(ref_cnt_reg, ref_en, snap);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      pending_reg   <= 1'b0;
      timer_reg     <= '0;
      trig_q_reg    <= '0;
      ref_q_reg     <= 1'b0;
      ref_cnt_reg   <= '0;
      ref_latch_reg <= '0;
      scal_new_reg  <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        cnt_reg[i]     <= '0;
        holding_reg[i] <= '0;
      end
    end else begin
      timer_reg   <= expire ? '0 : timer_reg + 1'b1;
      trig_q_reg  <= trig_i;
      ref_q_reg   <= refpulse_i;
      ref_cnt_reg <= ref_cnt_next;
      for (int i = 0; i < 32; i++) begin
        cnt_reg[i] <= cnt_next[i];
        if (snap) holding_reg[i] <= cnt_reg[i];
      end
      if (snap) ref_latch_reg <= ref_cnt_reg;

      case (state_reg)
        IDLE: begin
          pending_reg <= 1'b0;
          if (rd_first) state_reg <= READING;
        end
        READING: begin
          if (force_snap) begin
            state_reg   <= IDLE;
            pending_reg <= 1'b0;
          end else begin
            if (expire) pending_reg <= 1'b1;
            if (rd_last) state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (snap) scal_new_reg <= 1'b1;
      else if ((state_reg == READING) && rd_last) scal_new_reg <= 1'b0;
    end
  end

  assign scal_dat_o     = holding_reg[scal_addr_i];
  assign refpulse_cnt_o = ref_latch_reg;
  assign scal_new_o     = scal_new_reg;
  assign latch_o        = snap;

endmodule

// File: tb/tb_surf_scaler_bank.sv
// Directed bench for surf_scaler_bank: short-period instance for timing/readout behaviour,
// narrow-counter instance for saturation.
module tb_surf_scaler_bank;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] trig_i = '0;
  logic [31:0] mask_i = '0;
  logic        refpulse_i = 1'b0;
  logic [4:0]  scal_addr_i = '0;
  logic        scal_rd_i = 1'b0;
  logic [15:0] scal_dat_o;
  logic [15:0] refpulse_cnt_o;
  logic        scal_new_o;
  logic        latch_o;

  logic        rst_b = 1'b1;
  logic [31:0] trig_b = '0;
  logic [31:0] mask_b = '0;
  logic        ref_b = 1'b0;
  logic [4:0]  addr_b = '0;
  logic        rd_b = 1'b0;
  logic [7:0]  dat_b;
  logic [7:0]  refcnt_b;
  logic        new_b;
  logic        latch_b;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  surf_scaler_bank #(.PERIOD_CLKS(100), .CNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .trig_i(trig_i), .mask_i(mask_i),
    .refpulse_i(refpulse_i), .scal_addr_i(scal_addr_i), .scal_rd_i(scal_rd_i),
    .scal_dat_o(scal_dat_o), .refpulse_cnt_o(refpulse_cnt_o),
    .scal_new_o(scal_new_o), .latch_o(latch_o)
  );

  surf_scaler_bank #(.PERIOD_CLKS(700), .CNT_W(8)) u_dut_sat (
    .clk_i(clk_i), .rst_i(rst_b), .trig_i(trig_b), .mask_i(mask_b),
    .refpulse_i(ref_b), .scal_addr_i(addr_b), .scal_rd_i(rd_b),
    .scal_dat_o(dat_b), .refpulse_cnt_o(refcnt_b),
    .scal_new_o(new_b), .latch_o(latch_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end else begin
      $display("ok   %s = %0h (cycle %0d)", tag, obs, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    scal_addr_i = a;
    #1;
    check_eq(tag, scal_dat_o, exp);
  endtask

  task automatic pulse(input int ch);
    trig_i[ch] = 1'b1;
    tick();
    trig_i[ch] = 1'b0;
    tick();
  endtask

  task automatic rd_strobe(input logic [4:0] a);
    scal_addr_i = a;
    scal_rd_i   = 1'b1;
    tick();
    scal_rd_i   = 1'b0;
  endtask

  initial begin
    int n_latch;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_latch", latch_o, 0);
    check_eq("rst_new", scal_new_o, 0);
    check_eq("rst_refcnt", refpulse_cnt_o, 0);
    peek("rst_hold0", 5'd0, 0);
    rst_i = 1'b0;
    cyc = 0;

    // Period 0: basic counting
    for (int i = 0; i < 7; i++) pulse(0);
    trig_i[31] = 1'b1;
    repeat (5) tick();
    trig_i[31] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      refpulse_i = 1'b1; tick();
      refpulse_i = 1'b0; tick();
    end
    run_to(98);
    check_eq("latch@98", latch_o, 0);
    tick();
    check_eq("latch@99", latch_o, 1);
    tick();
    check_eq("latch@100", latch_o, 0);
    check_eq("new@100", scal_new_o, 1);
    check_eq("refcnt_p0", refpulse_cnt_o, 3);
    peek("hold0_p0", 5'd0, 7);
    peek("hold31_p0", 5'd31, 1);
    peek("hold1_p0", 5'd1, 0);
    peek("hold30_p0", 5'd30, 0);

    // Period 1: masking, and edges exactly on the latch cycle
    mask_i[3] = 1'b1;
    for (int i = 0; i < 10; i++) pulse(3);
    mask_i[3] = 1'b0;
    for (int i = 0; i < 4; i++) pulse(3);
    run_to(199);
    trig_i[2]  = 1'b1;
    refpulse_i = 1'b1;
    check_eq("latch@199", latch_o, 1);
    tick();
    trig_i[2]  = 1'b0;
    refpulse_i = 1'b0;
    peek("hold3_mask", 5'd3, 4);
    peek("hold2_edge_at_latch", 5'd2, 0);
    check_eq("refcnt_p1", refpulse_cnt_o, 0);

    // Period 2: snapshot coinciding with a read of address 0
    for (int i = 0; i < 3; i++) pulse(0);
    run_to(299);
    scal_addr_i = 5'd0;
    scal_rd_i   = 1'b1;
    #1;
    check_eq("dat_old@299", scal_dat_o, 0);
    check_eq("latch@299", latch_o, 1);
    tick();
    scal_rd_i = 1'b0;
    check_eq("dat_new@300", scal_dat_o, 3);
    peek("hold2_next_period", 5'd2, 1);
    check_eq("refcnt_p2", refpulse_cnt_o, 1);

    // Deferred snapshot released by reading address 31
    run_to(350);
    rd_strobe(5'd5);
    run_to(399);
    check_eq("latch_deferred@399", latch_o, 0);
    run_to(410);
    pulse(1);
    run_to(420);
    trig_i[1] = 1'b1;
    check_eq("latch@420", latch_o, 0);
    rd_strobe(5'd31);
    trig_i[1] = 1'b0;
    trig_i[8] = 1'b1;
    check_eq("latch_pending@421", latch_o, 1);
    tick();
    trig_i[8] = 1'b0;
    check_eq("latch@422", latch_o, 0);
    peek("hold1_deferred", 5'd1, 2);
    peek("hold8_deferred", 5'd8, 0);
    check_eq("new@422", scal_new_o, 1);
    rd_strobe(5'd0);
    run_to(430);
    rd_strobe(5'd31);
    check_eq("new_cleared@431", scal_new_o, 0);
    run_to(498);
    check_eq("latch@498", latch_o, 0);
    tick();
    check_eq("latch@499", latch_o, 1);
    tick();
    peek("hold8_p4", 5'd8, 1);
    peek("hold1_p4", 5'd1, 0);

    // Readout never finished: second expire forces the snapshot
    rd_strobe(5'd0);
    run_to(550);
    pulse(4);
    run_to(599);
    check_eq("latch_deferred@599", latch_o, 0);
    run_to(650);
    pulse(4);
    run_to(699);
    check_eq("latch_forced@699", latch_o, 1);
    tick();
    peek("hold4_forced", 5'd4, 2);
    run_to(799);
    check_eq("latch_idle@799", latch_o, 1);
    tick();
    peek("hold4_p7", 5'd4, 0);

    // Read of address 31 together with expire
    rd_strobe(5'd0);
    run_to(850);
    trig_i[6]  = 1'b1;
    refpulse_i = 1'b1;
    tick();
    trig_i[6]  = 1'b0;
    refpulse_i = 1'b0;
    run_to(899);
    check_eq("latch@899", latch_o, 0);
    rd_strobe(5'd31);
    check_eq("latch@900", latch_o, 1);
    check_eq("new@900", scal_new_o, 0);
    tick();
    check_eq("new@901", scal_new_o, 1);
    peek("hold6_p8", 5'd6, 1);
    check_eq("refcnt_p8", refpulse_cnt_o, 1);

    // Reset with a snapshot pending
    run_to(910);
    rd_strobe(5'd0);
    run_to(1010);
    peek("hold6_pre_rst", 5'd6, 1);
    rst_i = 1'b1;
    #1;
    check_eq("midrst_latch", latch_o, 0);
    check_eq("midrst_new", scal_new_o, 0);
    check_eq("midrst_refcnt", refpulse_cnt_o, 0);
    check_eq("midrst_hold6", scal_dat_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cyc = 0;
    trig_i[7] = 1'b1;
    n_latch = int'(latch_o);
    tick();
    trig_i[7] = 1'b0;
    while (cyc < 98) begin
      n_latch += int'(latch_o);
      tick();
    end
    n_latch += int'(latch_o);
    check_eq("no_latch_after_rst", n_latch, 0);
    tick();
    check_eq("latch_after_rst@99", latch_o, 1);
    tick();
    peek("hold7_after_rst", 5'd7, 1);
    peek("hold6_after_rst", 5'd6, 0);
    check_eq("new_after_rst", scal_new_o, 1);

    // Saturation on the narrow-counter instance
    rst_b = 1'b0;
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      trig_b[5] = 1'b1; tick();
      trig_b[5] = 1'b0; tick();
    end
    run_to(699);
    check_eq("sat_latch@699", latch_b, 1);
    tick();
    addr_b = 5'd5;
    #1;
    check_eq("sat_hold5", dat_b, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      trig_b[5] = 1'b1; tick();
      trig_b[5] = 1'b0; tick();
    end
    run_to(1400);
    #1;
    check_eq("sat_hold5_next", dat_b, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
